// File: rtl/sd_radix10_to_bcd_if.sv
// Bus bundle for the signed-digit radix-10 to BCD converter.
// The master starts a conversion and the slave (the converter) answers with results.
interface sd_radix10_to_bcd_if #(
  parameter int NDIG = 16
);
  logic                start;
  logic [5*NDIG-1:0]   sd_mag;
  logic [NDIG-1:0]     sd_sign;
  logic                busy;
  logic                done;
  logic [4*NDIG-1:0]   bcd;
  logic                neg;
  logic                err;

  modport master (
    output start, sd_mag, sd_sign,
    input  busy, done, bcd, neg, err
  );

  modport slave (
    input  start, sd_mag, sd_sign,
    output busy, done, bcd, neg, err
  );
endinterface

// File: rtl/sd_radix10_to_bcd.sv
// Serial signed-digit radix-10 to BCD converter.
// Each digit is a one-hot magnitude (0..5) plus a sign bit. Digits are
// folded least significant first through a single decimal borrow chain,
// one per cycle. A negative operand leaves its 10^NDIG complement in bcd
// and raises neg. A final cycle after the last digit latches neg, then a
// one-cycle DONE state pulses done.
module sd_radix10_to_bcd #(
  parameter int NDIG = 16
) (
  input logic              clk,
  input logic              rst,
  sd_radix10_to_bcd_if.slave bus
);

  localparam int            CW   = $clog2(NDIG + 1);
  localparam logic [CW-1:0] LAST = CW'(NDIG);

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    DONE
  } state_t;

  state_t              state;
  state_t              state_next;

  logic [5*NDIG-1:0]   mag_q;
  logic [NDIG-1:0]     sign_q;
  logic                borrow_q;
  logic [CW-1:0]       cnt_q;
  logic [4*NDIG-1:0]   bcd_q;
  logic                neg_q;
  logic                err_q;

  logic [4:0]          mag_lo;
  logic                sign_lo;
  logic                multi;
  logic [2:0]          mval;
  logic [4:0]          dval;
  logic [4:0]          tval;
  logic                borrow_out;
  logic [3:0]          digit;
  logic                digit_cycle;

  // Decode the digit currently at the bottom of the shift registers and subtract the borrow
  always_comb begin
    mag_lo  = mag_q[4:0];
    sign_lo = sign_q[0];
    multi   = (mag_lo & (mag_lo - 5'd1)) != 5'd0;
    case (mag_lo)
      5'b00001: mval = 3'd1;
      5'b00010: mval = 3'd2;
      5'b00100: mval = 3'd3;
      5'b01000: mval = 3'd4;
      5'b10000: mval = 3'd5;
      default:  mval = 3'd0;
    endcase
    dval       = sign_lo ? (5'd0 - {2'b00, mval}) : {2'b00, mval};
    tval       = dval - {4'd0, borrow_q};
    borrow_out = tval[4];
    digit      = borrow_out ? (tval[3:0] + 4'd10) : tval[3:0];
  end

  assign digit_cycle = (state == CONV) && (cnt_q != LAST);

  // Next-state logic for the IDLE/CONV/DONE sequence
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.start) state_next = CONV;
      CONV:    if (cnt_q == LAST) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Operand capture, digit-serial datapath and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      mag_q    <= '0;
      sign_q   <= '0;
      borrow_q <= 1'b0;
      cnt_q    <= '0;
      bcd_q    <= '0;
      neg_q    <= 1'b0;
      err_q    <= 1'b0;
    end else if (state == IDLE && bus.start) begin
      mag_q    <= bus.sd_mag;
      sign_q   <= bus.sd_sign;
      borrow_q <= 1'b0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
    end else if (digit_cycle) begin
      for (int i = 0; i < NDIG; i++) begin
        if (cnt_q == CW'(i)) begin
          bcd_q[4*i +: 4] <= digit;
        end
      end
      borrow_q <= borrow_out;
      err_q    <= err_q | multi;
      mag_q    <= mag_q >> 5;
      sign_q   <= sign_q >> 1;
      cnt_q    <= cnt_q + 1'b1;
    end else if (state == CONV) begin
      neg_q <= borrow_q;
    end
  end

  assign bus.busy = (state != IDLE);
  assign bus.done = (state == DONE);
  assign bus.bcd  = bcd_q;
  assign bus.neg  = neg_q;
  assign bus.err  = err_q;

endmodule

// File: doc/sd_radix10_to_bcd.md
SD_RADIX10_TO_BCD -- requirements
Module: sd_radix10_to_bcd

Interface
REQ-001 Parameter NDIG, default 16, number of signed-digit radix-10 digits per operand; legal range 2..32.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request to convert the operand on sd_mag/sd_sign; sampled only in IDLE.
REQ-005 sd_mag  input  5*NDIG  per digit i, bits [5i+4:5i] = {y5,y4,y3,y2,y1}: one-hot magnitude select, all-zero = magnitude 0.
REQ-006 sd_sign  input  NDIG  per digit i, ys: 1 = negative digit, 0 = positive digit.
REQ-007 busy  output  1  high while a conversion is in progress, including the done cycle.
REQ-008 done  output  1  single-cycle pulse marking bcd/neg/err valid.
REQ-009 bcd  output  4*NDIG  BCD result; digit i at [4i+3:4i], digit 0 least significant.
REQ-010 neg  output  1  operand value was negative; bcd then holds its 10^NDIG complement.
REQ-011 err  output  1  at least one digit had more than one magnitude bit set.

Function
REQ-012 Digit value d_i = (ys ? -1 : +1) * m_i, with m_i in {0..5} from the one-hot field; ys=1 with m_i=0 is decoded as 0 without error.
REQ-013 The block operates in three states: IDLE, CONV, DONE.
REQ-014 In IDLE with start=1, sd_mag and sd_sign are captured into internal registers, the borrow is cleared, the digit counter is cleared, err is cleared, and the next state is CONV.
REQ-015 In IDLE with start=0, the block stays in IDLE with all outputs held.
REQ-016 In CONV, exactly one digit is processed per cycle, least significant first: t = d_i - borrow_in.
REQ-017 If t < 0, the output digit is t+10 and borrow_out=1; otherwise the output digit is t and borrow_out=0; every output digit is in 0..9.
REQ-018 Each output digit is written to bcd position i in the cycle digit i is processed; the borrow register takes borrow_out.
REQ-019 A digit with more than one magnitude bit set is processed as d_i=0 and sets err; err stays set until the next accepted start or reset.
REQ-020 After the digit NDIG-1 cycle, the next state is DONE; neg equals the final borrow_out.
REQ-021 DONE lasts exactly one cycle, asserts done=1, and then returns to IDLE.
REQ-022 Latency: for start accepted at edge k, done=1 in the cycle following edge k+NDIG+1, i.e. NDIG+1 cycles after acceptance.
REQ-023 busy=1 in CONV and DONE, and 0 in IDLE.
REQ-024 start is ignored while busy=1, including in the DONE cycle; inputs may change freely after acceptance without affecting the result.
REQ-025 bcd, neg and err hold their final values after done until the next accepted start, then update as processing proceeds.
REQ-026 The all-positive 5s operand (d_i=+5 for all i) converts with no borrow; an all-negative operand produces neg=1.

Reset
REQ-027 With rst=1 at a rising edge, the next state is IDLE and busy=0, done=0, bcd=0, neg=0, err=0, the borrow is 0 and the digit counter is 0.
REQ-028 Reset takes priority over start and over any in-progress conversion; a conversion interrupted by reset produces no done.
REQ-029 Outputs after reset release are stable until the first accepted start.

Verification (NDIG=4, digits written MSD..LSD)
REQ-030 Operand +1,-2,+3,-4 with start pulse -> done exactly 5 cycles later, bcd=16'h0826, neg=0, err=0.
REQ-031 Operand 0,0,0,-1 -> bcd=16'h9999, neg=1, err=0; operand +5,+5,+5,+5 -> bcd=16'h5555, neg=0.
REQ-032 Operand with negative zero (ys=1, magnitude 0) on every digit -> bcd=16'h0000, neg=0, err=0.
REQ-033 Digit 2 magnitude field 5'b10001, other digits 0 -> err=1, digit 2 decoded as 0, bcd=16'h0000; the next valid conversion clears err.
REQ-034 Start re-pulsed during CONV and in the DONE cycle -> ignored, with exactly one done per accepted start; rst asserted mid-CONV -> all outputs 0, no done, and a new start afterwards converts correctly.
